// File: rtl/iter_divider16.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake,
// signed/unsigned modes with explicit divide-by-zero result.
module iter_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic             op_signed, dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_sh, dvs_mag, part_rem, quo_sh;
    logic [CW-1:0]    count;

    logic             accept, last_iter, q_bit;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
    logic [WIDTH-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

    always_comb begin
        accept    = start && (state == IDLE || state == DONE);
        last_iter = (count == CW'(WIDTH - 1));
        state_nx  = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nx = (divisor == '0) ? DONE : RUN;
                else        state_nx = IDLE;
            end
            RUN:     if (last_iter) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // The shifted-out remainder MSB is kept in the trial so divisors above
    // 2^(WIDTH-1) still divide correctly; the extra top bit is the borrow.
    always_comb begin
        dvd_mag_in = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_mag_in = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        trial      = {1'b0, part_rem, dvd_sh[WIDTH-1]} - {2'b00, dvs_mag};
        q_bit      = ~trial[WIDTH+1];
        rem_nx     = q_bit ? trial[WIDTH-1:0] : {part_rem[WIDTH-2:0], dvd_sh[WIDTH-1]};
        quo_nx     = {quo_sh[WIDTH-2:0], q_bit};
        quo_fix    = (op_signed && (dvd_neg ^ dvs_neg)) ? -quo_nx : quo_nx;
        rem_fix    = (op_signed && dvd_neg) ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_signed   <= 1'b0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            dvd_sh      <= '0;
            dvs_mag     <= '0;
            part_rem    <= '0;
            quo_sh      <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_signed   <= signed_op;
            dvd_neg     <= signed_op & dividend[WIDTH-1];
            dvs_neg     <= signed_op & divisor[WIDTH-1];
            dvd_sh      <= dvd_mag_in;
            dvs_mag     <= dvs_mag_in;
            part_rem    <= '0;
            quo_sh      <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            dvd_sh   <= dvd_sh << 1;
            part_rem <= rem_nx;
            quo_sh   <= quo_nx;
            count    <= count + CW'(1);
            if (last_iter) begin
                quotient  <= quo_fix;
                remainder <= rem_fix;
            end
        end
    end

endmodule

// File: tb/tb_iter_divider16.sv
// Scoreboard bench for iter_divider16: stimulus pushes model results, a negedge
// monitor pops and checks them whenever done is presented.
module tb_iter_divider16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    iter_divider16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division truncating toward zero.
    function automatic exp_t model(input logic so, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   sa, sd, qi, ri;
        e.acc = 0;
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1; e.lat = 0;
        end else begin
            e.dbz = 1'b0; e.lat = 16;
            if (so) begin
                sa = $signed(a);
                sd = $signed(b);
                qi = sa / sd;
                ri = sa % sd;
                e.q = qi[15:0];
                e.r = ri[15:0];
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic so, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        start = 1'b1; signed_op = so; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        signed_op = 1'($urandom);
        e = model(so, a, b);
        e.acc = cyc;
        sb.push_back(e);
        chk("busy_after_accept", 32'(busy), 32'(b != 16'd0));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        chk("done_seen", 32'(done), 32'd1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want no pending op at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic so;
        logic [15:0] a, b;
        int unsigned sel;

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 16'd100, 16'd7);      wait_drain();
        issue(1'b1, 16'hFFF9, 16'h0002);  wait_drain();
        issue(1'b1, 16'h0007, 16'hFFFE);  wait_drain();
        issue(1'b0, 16'h1234, 16'h0000);  wait_drain();
        issue(1'b1, 16'h1234, 16'h0000);  wait_drain();
        issue(1'b1, 16'h8000, 16'hFFFF);  wait_drain();
        issue(1'b0, 16'hFFFF, 16'h0001);  wait_drain();
        issue(1'b0, 16'd5, 16'd9);        wait_drain();
        issue(1'b0, 16'hFFFF, 16'hFFFE);  wait_drain();
        issue(1'b0, 16'h8000, 16'hFFFF);  wait_drain();

        // start during RUN is ignored; start during DONE is accepted
        issue(1'b0, 16'd1000, 16'd3);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; signed_op = 1'b0; dividend = 16'd50; divisor = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_ignored_start", 32'(busy), 32'd1);
        wait_done();
        issue(1'b1, 16'hFED4, 16'd7);
        wait_drain();

        // reset mid-operation aborts with no done pulse
        issue(1'b0, 16'd40000, 16'd3);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_after_abort", 32'(done), 32'd0);
        issue(1'b0, 16'd1000, 16'd10);
        wait_drain();

        for (int i = 0; i < 300; i++) begin
            so  = 1'($urandom);
            a   = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 16'd0;
            else if (sel == 1) begin a = 16'h8000; b = 16'hFFFF; end
            else if (sel == 2) b = 16'($urandom_range(1, 15));
            else               b = 16'($urandom);
            issue(so, a, b);
            if ($urandom_range(0, 3) != 0) wait_drain();
            else                            wait_done();
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
